// File: rtl/bus_burst_responder_pkg.sv
// Shared definitions for the burst responder: FSM state encoding, default
// window placement and the address-window helper functions.
package bus_burst_responder_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h5000_0000;
    localparam int          DEFAULT_ADDR_BITS = 9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_FETCH = 3'd2,
        S_READ     = 3'd3,
        S_RD_END   = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    // Byte address falls inside the window (upper bits equal the base).
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          addr_bits);
        return (addr >> (addr_bits + 2)) == (base >> (addr_bits + 2));
    endfunction

    // Word aligned and the whole burst stays inside the window.
    function automatic logic window_ok(input logic [31:0] addr,
                                       input logic [7:0]  burst_size,
                                       input int          addr_bits);
        logic [31:0] offset;
        logic [31:0] words;
        words  = 32'd1 << addr_bits;
        offset = (addr >> 2) & (words - 32'd1);
        return (addr[1:0] == 2'b00) && ((offset + 32'(burst_size) + 32'd1) <= words);
    endfunction

endpackage

// File: rtl/bus_burst_responder_if.sv
// Bus-side signal bundle of the burst responder. The slave modport is the
// responder's view, the master modport the initiator's view.
interface bus_burst_responder_if;

    logic        in_beginTransaction;
    logic        in_endTransaction;
    logic        in_readNotWrite;
    logic [31:0] in_addressData;
    logic [7:0]  in_burstSize;
    logic        in_dataValid;
    logic        in_busy;
    logic        in_error;
    logic [31:0] out_addressData;
    logic        out_dataValid;
    logic        out_endTransaction;
    logic        out_busy;
    logic        out_error;

    modport slave (
        input  in_beginTransaction, in_endTransaction, in_readNotWrite,
               in_addressData, in_burstSize, in_dataValid, in_busy, in_error,
        output out_addressData, out_dataValid, out_endTransaction,
               out_busy, out_error
    );

    modport master (
        output in_beginTransaction, in_endTransaction, in_readNotWrite,
               in_addressData, in_burstSize, in_dataValid, in_busy, in_error,
        input  out_addressData, out_dataValid, out_endTransaction,
               out_busy, out_error
    );

endinterface

// File: rtl/bus_burst_responder_ssram.sv
// Dual-port synchronous SRAM, single clock, registered read data on both
// ports (read-first). Contents are never reset.
module dualPortSSRAM #(
    parameter  int bitwidth    = 32,
    parameter  int nrOfEntries = 512,
    localparam int AW          = $clog2(nrOfEntries)
) (
    input  logic                clock,
    input  logic                writeEnableA,
    input  logic [AW-1:0]       addressA,
    input  logic [bitwidth-1:0] dataInA,
    output logic [bitwidth-1:0] dataOutA,
    input  logic                writeEnableB,
    input  logic [AW-1:0]       addressB,
    input  logic [bitwidth-1:0] dataInB,
    output logic [bitwidth-1:0] dataOutB
);

    logic [bitwidth-1:0] mem_q [nrOfEntries];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clock) begin
        if (writeEnableA) mem_q[addressA] <= dataInA;
        if (writeEnableB) mem_q[addressB] <= dataInB;
        dataOutA <= mem_q[addressA];
        dataOutB <= mem_q[addressB];
    end

endmodule

// File: rtl/bus_burst_responder.sv
// Burst responder owning a private word-addressed SSRAM window on the SoC bus.
// Optional feature macro: RESPONDER_WAIT_STATE_EN (one write wait state per
// four accepted beats); without it out_busy is constant 0.
//
// state      | meaning
// S_IDLE     | waiting for a begin that hits the window
// S_WRITE    | accepting write beats until end, overflow or abort
// S_RD_FETCH | first SSRAM read issued for the burst start offset
// S_READ     | presenting read beat cnt_q, held while in_busy
// S_RD_END   | one-cycle out_endTransaction
// S_ERROR    | one-cycle out_error
module bus_burst_responder
    import bus_burst_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    bus_burst_responder_if.slave    bus
);

    state_t               state_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [7:0]           burst_q;
    logic [8:0]           cnt_q;
    logic                 valid_q;
    logic                 end_q;
    logic                 err_q;

    logic                 begin_hit;
    logic                 begin_ok;
    logic                 busy;
    logic                 accept;
    logic                 overflow;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_rdata;
    logic [31:0]          ssram_b_unused;

    assign begin_hit = bus.in_beginTransaction & addr_hit(bus.in_addressData, BASE_ADDR, ADDR_BITS);
    assign begin_ok  = window_ok(bus.in_addressData, bus.in_burstSize, ADDR_BITS);

`ifdef RESPONDER_WAIT_STATE_EN
    logic busy_prev_q;

    // Remember last cycle's stall so a wait state is never two cycles long.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy_prev_q <= 1'b0;
        else        busy_prev_q <= busy;
    end

    assign busy = (state_q == S_WRITE) && (cnt_q[1:0] == 2'b11) && !busy_prev_q;
`else
    assign busy = 1'b0;
`endif

    assign accept   = (state_q == S_WRITE) && bus.in_dataValid && !busy && !bus.in_error;
    assign overflow = cnt_q > {1'b0, burst_q};
    assign ram_we   = accept && !overflow;

    // SSRAM port A address: write slot, or the beat to show next cycle
    // (current beat again under stall so the read data stays stable).
    always_comb begin
        ram_addr = base_q;
        if (state_q == S_WRITE)
            ram_addr = base_q + ADDR_BITS'(cnt_q);
        else if (state_q == S_READ)
            ram_addr = base_q + ADDR_BITS'(cnt_q) + ADDR_BITS'(!bus.in_busy);
    end

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (begin_hit) begin
                        base_q  <= bus.in_addressData[ADDR_BITS+1:2];
                        burst_q <= bus.in_burstSize;
                        cnt_q   <= '0;
                        if (!begin_ok) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else if (bus.in_readNotWrite) begin
                            state_q <= S_RD_FETCH;
                        end else begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.in_error) begin
                        state_q <= S_IDLE;
                    end else if (accept && overflow) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        if (accept) cnt_q <= cnt_q + 9'd1;
                        if (bus.in_endTransaction) state_q <= S_IDLE;
                    end
                end
                S_RD_FETCH: begin
                    if (bus.in_error) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_READ;
                        valid_q <= 1'b1;
                    end
                end
                S_READ: begin
                    if (bus.in_error) begin
                        state_q <= S_IDLE;
                    end else if (bus.in_busy) begin
                        valid_q <= 1'b1;
                    end else if (cnt_q == {1'b0, burst_q}) begin
                        state_q <= S_RD_END;
                        end_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 9'd1;
                        valid_q <= 1'b1;
                    end
                end
                S_RD_END: state_q <= S_IDLE;
                S_ERROR:  state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_addressData    = valid_q ? ram_rdata : 32'd0;
    assign bus.out_dataValid      = valid_q;
    assign bus.out_endTransaction = end_q;
    assign bus.out_busy           = busy;
    assign bus.out_error          = err_q;

    dualPortSSRAM #(
        .bitwidth    (32),
        .nrOfEntries (1 << ADDR_BITS)
    ) u_ssram (
        .clock        (clock),
        .writeEnableA (ram_we),
        .addressA     (ram_addr),
        .dataInA      (bus.in_addressData),
        .dataOutA     (ram_rdata),
        .writeEnableB (1'b0),
        .addressB     ('0),
        .dataInB      (32'd0),
        .dataOutB     (ssram_b_unused)
    );

endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed plus randomized bench for bus_burst_responder. A word-array model
// of the window holds expected contents; read timing is predicted from the
// beat/stall sequence the bench itself drives.
module tb_bus_burst_responder;

    localparam logic [31:0] BASE = 32'h5000_0000;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem_m [512];
    bit          known [512];
    logic [31:0] wdata [256];

    bus_burst_responder_if bus ();

    bus_burst_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_dataValid), 32'd0);
        chk({tag, "_data"},  bus.out_addressData,    32'd0);
        chk({tag, "_end"},   32'(bus.out_endTransaction), 32'd0);
        chk({tag, "_busy"},  32'(bus.out_busy),      32'd0);
        chk({tag, "_err"},   32'(bus.out_error),     32'd0);
    endtask

    task automatic clear_inputs();
        bus.in_beginTransaction = 1'b0;
        bus.in_endTransaction   = 1'b0;
        bus.in_readNotWrite     = 1'b0;
        bus.in_addressData      = 32'd0;
        bus.in_burstSize        = 8'd0;
        bus.in_dataValid        = 1'b0;
        bus.in_busy             = 1'b0;
        bus.in_error            = 1'b0;
    endtask

    task automatic drive_begin(input logic [31:0] addr, input int n, input bit rnw);
        @(negedge clock);
        bus.in_beginTransaction = 1'b1;
        bus.in_readNotWrite     = rnw;
        bus.in_addressData      = addr;
        bus.in_burstSize        = 8'(n - 1);
        bus.in_dataValid        = 1'b0;
        bus.in_endTransaction   = 1'b0;
        bus.in_busy             = 1'b0;
    endtask

    // Write burst of N beats announced, `sent` beats driven from wdata[].
    task automatic do_write(input logic [31:0] addr, input int n, input int sent, input bit end_with_last);
        bit hit, bad;
        int off, i, guard;
        hit = (addr[31:11] == BASE[31:11]);
        off = int'(addr[10:2]);
        bad = (addr[1:0] != 2'b00) || (off + n > 512);
        drive_begin(addr, n, 1'b0);
        if (!hit) begin
            @(negedge clock);
            clear_inputs();
            chk_idle("wr_miss0");
            @(negedge clock);
            chk_idle("wr_miss1");
            return;
        end
        if (bad) begin
            @(negedge clock);
            clear_inputs();
            chk("wr_bad_err_pulse", 32'(bus.out_error), 32'd1);
            @(negedge clock);
            chk("wr_bad_err_clear", 32'(bus.out_error), 32'd0);
            return;
        end
        i = 0;
        guard = 0;
        while (i < sent && guard < 4 * sent + 4) begin
            @(negedge clock);
            bus.in_beginTransaction = 1'b0;
            bus.in_dataValid        = 1'b1;
            bus.in_addressData      = wdata[i];
            bus.in_endTransaction   = end_with_last && (i == sent - 1) && !bus.out_busy;
            chk("wr_no_err", 32'(bus.out_error), 32'd0);
`ifndef RESPONDER_WAIT_STATE_EN
            chk("wr_busy_zero", 32'(bus.out_busy), 32'd0);
`endif
            if (!bus.out_busy) begin
                if (i < n) begin
                    mem_m[(off + i) % 512] = wdata[i];
                    known[(off + i) % 512] = 1'b1;
                end
                i++;
            end
            guard++;
        end
        chk("wr_beats_sent", 32'(i), 32'(sent));
        @(negedge clock);
        clear_inputs();
        chk("wr_err_after_beats", 32'(bus.out_error), (sent > n) ? 32'd1 : 32'd0);
        if (sent <= n && !end_with_last) begin
            bus.in_endTransaction = 1'b1;
            @(negedge clock);
            bus.in_endTransaction = 1'b0;
            chk("wr_end_no_err", 32'(bus.out_error), 32'd0);
        end
    endtask

    // Read burst; beat stall_beat is stalled for stall_len cycles.
    task automatic do_read(input logic [31:0] addr, input int n, input int stall_beat, input int stall_len);
        bit hit, bad;
        int off, k, stalls;
        hit = (addr[31:11] == BASE[31:11]);
        off = int'(addr[10:2]);
        bad = (addr[1:0] != 2'b00) || (off + n > 512);
        drive_begin(addr, n, 1'b1);
        @(negedge clock);
        clear_inputs();
        if (!hit) begin
            for (int c = 0; c < 4; c++) begin
                chk_idle("rd_miss");
                @(negedge clock);
            end
            return;
        end
        if (bad) begin
            chk("rd_bad_err_pulse", 32'(bus.out_error), 32'd1);
            chk("rd_bad_no_valid", 32'(bus.out_dataValid), 32'd0);
            @(negedge clock);
            chk("rd_bad_err_clear", 32'(bus.out_error), 32'd0);
            return;
        end
        chk("rd_fetch_no_valid", 32'(bus.out_dataValid), 32'd0);
        k = 0;
        stalls = 0;
        for (int guard = 0; guard < n + stall_len + 2 && k < n; guard++) begin
            @(negedge clock);
            chk("rd_valid", 32'(bus.out_dataValid), 32'd1);
            chk("rd_no_end", 32'(bus.out_endTransaction), 32'd0);
            if (known[(off + k) % 512])
                chk($sformatf("rd_data_beat%0d", k), bus.out_addressData, mem_m[(off + k) % 512]);
            if (k == stall_beat && stalls < stall_len) begin
                bus.in_busy = 1'b1;
                stalls++;
            end else begin
                bus.in_busy = 1'b0;
                k++;
            end
        end
        @(negedge clock);
        bus.in_busy = 1'b0;
        chk("rd_end_pulse", 32'(bus.out_endTransaction), 32'd1);
        chk("rd_end_valid_low", 32'(bus.out_dataValid), 32'd0);
        chk("rd_end_data_zero", bus.out_addressData, 32'd0);
        @(negedge clock);
        chk("rd_end_clear", 32'(bus.out_endTransaction), 32'd0);
    endtask

    initial begin
        int n, sent, off;
        clock = 1'b0;
        reset = 1'b0;
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 512; i++) known[i] = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clock);
        chk_idle("post_reset");

        // Basic write 0x11..0x44 to words 4..7, then plain and stalled reads.
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
        do_write(BASE + 32'h10, 4, 4, 1'b0);
        do_read(BASE + 32'h10, 4, 0, 0);
        do_read(BASE + 32'h10, 4, 1, 3);

        // Misaligned and window-overrun begins, then memory unchanged.
        wdata[0] = 32'hDEAD_0001; wdata[1] = 32'hDEAD_0002;
        wdata[2] = 32'hDEAD_0003; wdata[3] = 32'hDEAD_0004;
        do_write(BASE + 32'h12, 4, 4, 1'b0);
        do_write(BASE + 32'h7F8, 4, 4, 1'b0);
        do_read(BASE + 32'h7F8, 4, 0, 0);
        do_read(BASE + 32'h10, 4, 0, 0);

        // Address miss: nothing answers.
        do_read(32'h6000_0000, 4, 0, 0);
        do_write(32'h6000_0000, 4, 4, 1'b0);

        // Overflow: N=2 with 3 beats, third beat must not land in word 18.
        wdata[0] = 32'hA5A5_A5A5;
        do_write(BASE + 32'h48, 1, 1, 1'b1);
        wdata[0] = $urandom; wdata[1] = $urandom; wdata[2] = $urandom;
        do_write(BASE + 32'h40, 2, 3, 1'b0);
        do_read(BASE + 32'h40, 3, 2, 1);

        // Short burst with last beat and end together.
        for (int i = 0; i < 4; i++) wdata[i] = $urandom;
        do_write(BASE + 32'h80, 4, 3, 1'b1);
        do_read(BASE + 32'h80, 3, 0, 2);

        // Last legal window position.
        for (int i = 0; i < 4; i++) wdata[i] = $urandom;
        do_write(BASE + 32'h7F0, 4, 4, 1'b1);
        do_read(BASE + 32'h7F0, 4, 3, 1);

        // Initiator abort on the third write beat.
        for (int i = 0; i < 4; i++) wdata[i] = $urandom;
        do_write(BASE + 32'h100, 4, 4, 1'b0);
        drive_begin(BASE + 32'h100, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.in_beginTransaction = 1'b0;
            bus.in_dataValid        = 1'b1;
            bus.in_addressData      = 32'hC0DE_0000 + 32'(i);
            bus.in_error            = (i == 2);
            if (i < 2) mem_m[64 + i] = 32'hC0DE_0000 + 32'(i);
        end
        @(negedge clock);
        clear_inputs();
        chk_idle("abort");
        do_read(BASE + 32'h100, 4, 2, 1);

        // Reset pulled mid-read: outputs drop at once, memory survives.
        drive_begin(BASE + 32'h10, 4, 1'b1);
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        chk("rst_mid_valid_before", 32'(bus.out_dataValid), 32'd1);
        chk("rst_mid_data_before", bus.out_addressData, mem_m[4]);
        #2 reset = 1'b0;
        #1 chk_idle("rst_mid");
        @(negedge clock);
        chk_idle("rst_hold");
        #2 reset = 1'b1;
        do_read(BASE + 32'h10, 4, 0, 0);

        // Randomized bursts anywhere in the window.
        for (int it = 0; it < 10; it++) begin
            n    = $urandom_range(1, 16);
            sent = $urandom_range(1, n);
            off  = $urandom_range(0, 512 - n);
            for (int i = 0; i < n; i++) wdata[i] = $urandom;
            do_write(BASE + 32'(off * 4), n, sent, 1'($urandom_range(0, 1)));
            do_read(BASE + 32'(off * 4), n, $urandom_range(0, n - 1), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_burst_responder.md
# bus_burst_responder

Memory-mapped burst responder (bus slave) for the shared SoC bus, owning a private word-addressed SSRAM window. Serves the bus-side end of burst transactions issued by initiators such as the DMA custom instruction. Decodes `begin transaction`, accepts write bursts into the SSRAM, returns read bursts with `dataValid`/`endTransaction`, applies back-pressure, and flags errors.

## Interface
- `BASE_ADDR`, 32'h5000_0000: byte base address of window, aligned to window size
- `ADDR_BITS`, 9: word-address width; window = 2^ADDR_BITS words
- `clock` in 1: sole clock, rising edge
- `reset` in 1: **asynchronous, active-low**; all state cleared while 0
- `in_beginTransaction` in 1: one-cycle transaction start
- `in_endTransaction` in 1: initiator ends a write burst
- `in_readNotWrite` in 1: 1 = initiator reads from responder; sampled with begin
- `in_addressData` in 32: byte address on begin, write data on beats
- `in_burstSize` in 8: beats minus one (N = in_burstSize+1), sampled with begin
- `in_dataValid` in 1: write beat valid
- `in_busy` in 1: initiator stalls read beats
- `in_error` in 1: initiator aborts
- `out_addressData` out 32: read data; 0 when not valid
- `out_dataValid` out 1: read beat valid
- `out_endTransaction` out 1: one-cycle end of read burst
- `out_busy` out 1: responder stalls write beats
- `out_error` out 1: one-cycle error pulse

## Operation
- Hit: `in_addressData[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]`. Miss: ignore, stay IDLE, outputs 0.
- Hit with `addr[1:0]!=0`, or word offset + N > 2^ADDR_BITS: ERROR.
- States: IDLE, WRITE, RD_FETCH, READ, RD_END, ERROR.
- IDLE -> WRITE (hit, ok, write), RD_FETCH (hit, ok, read), ERROR (hit, bad). `in_beginTransaction` outside IDLE is ignored.
- WRITE: beat accepted when `in_dataValid & ~out_busy`. Stored at offset+count. Count is 9 bits. Beat N+1 -> ERROR, not written. `in_endTransaction` -> IDLE. Fewer than N beats is legal, with no error.
- RD_FETCH: issue SSRAM read for offset, then go to READ.
- READ: present beat k. Advance only when `in_busy`=0. Under stall, data and valid are held stable. After beat N-1 is accepted -> RD_END.
- RD_END: `out_endTransaction`=1 for one cycle -> IDLE.
- ERROR: `out_error`=1 for one cycle -> IDLE.
- `in_error` in any non-IDLE state: abort to IDLE next cycle, outputs 0, pending writes not completed.
- Unused outputs are driven 0 so the bus can OR-combine.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Begin sampled at edge T. Read: first `out_dataValid` at T+2. Beat k at T+2+k when unstalled. `out_endTransaction` at T+2+N.
- Write: zero wait states without `RESPONDER_WAIT_STATE_EN`. Beat sampled at T+1 onward is stored at the same edge.
- Error: `out_error` at T+1.
- Reset asserted mid-burst: immediate return to IDLE. SSRAM contents are not cleared.
- Simultaneous `in_dataValid` and `in_endTransaction`: the beat is stored, then IDLE.

## Configuration
- `RESPONDER_WAIT_STATE_EN` defined: in WRITE, `out_busy`=1 on every cycle where accepted-beat count[1:0]==3 and the previous cycle was not busy. This gives one wait state per 4 beats. Beats seen while busy are not accepted.
- Undefined: `out_busy` is constant 0.

## Structure
- Shared package/header: state encodings, `BASE_ADDR` default, window-check helper.
- Sub-module: the codebase `dualPortSSRAM`.
  - Port A: bus writes and reads.
  - Port B: tied off.
  - bitwidth 32, nrOfEntries 2^ADDR_BITS.

## Test plan
- Write 4 beats to 0x5000_0010, data 0x11..0x44, then `in_endTransaction` -> words 4..7 hold 0x11..0x44, no `out_error`.
- Read N=4 from 0x5000_0010 -> `out_dataValid` at T+2..T+5 with 0x11..0x44, `out_endTransaction` at T+6.
- Same read with `in_busy` high on beat 2 for 3 cycles -> 0x22 held 4 cycles, order preserved, end delayed 3 cycles.
- Begin at 0x5000_0012, or offset 510 with N=4 -> `out_error` pulse at T+1, memory unchanged.
- Begin at 0x6000_0000 -> all outputs stay 0, state IDLE.
- Write with N=2 and 3 valid beats -> third beat not stored, `out_error` pulse. Reset low mid-read -> outputs 0 immediately.
